// File: rtl/fd_skid_buffer.sv
// Two-entry fetch/decode skid buffer: registered MAIN (head) and SKID slots, flush and sync reset.
// Optional macro FD_SKID_BUFFER_STATS_EN adds a saturating flush_drop_cnt output.
module fd_skid_buffer #(
  parameter int                  INSTR_W   = 16,
  parameter int                  PC_W      = 32,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic [1:0]         occupancy
`ifdef FD_SKID_BUFFER_STATS_EN
  ,
  output logic [15:0]        flush_drop_cnt
`endif
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;

  logic accept;
  logic take;

  assign accept = in_valid && in_ready;
  assign take   = out_valid && out_ready;

  // NOTE: all state, including the data slots, is cleared by reset so pc_out and SKID read 0 afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_d = ONE;
        ONE: begin
          if (accept && !take)      state_d = TWO;
          else if (!accept && take) state_d = EMPTY;
        end
        TWO:     if (take) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      main_instr_d = NOP_INSTR;
      main_pc_d    = '0;
      skid_instr_d = '0;
      skid_pc_d    = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_instr_d = instr_in;
            main_pc_d    = pc_in;
          end
        end
        ONE: begin
          if (accept && take) begin
            main_instr_d = instr_in;
            main_pc_d    = pc_in;
          end else if (accept) begin
            skid_instr_d = instr_in;
            skid_pc_d    = pc_in;
          end else if (take) begin
            // Draining to EMPTY shows NOP but keeps the last PC visible.
            main_instr_d = NOP_INSTR;
          end
        end
        TWO: begin
          if (take) begin
            main_instr_d = skid_instr_q;
            main_pc_d    = skid_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = (state_q != TWO) && !rst;
    occupancy = state_q;
    instr_out = main_instr_q;
    pc_out    = main_pc_q;
  end

`ifdef FD_SKID_BUFFER_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + 17'(occupancy) + 17'(accept);
    drop_cnt_d = drop_cnt_q;
    if (flush) drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign flush_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fd_skid_buffer.sv
// Self-checking bench for fd_skid_buffer: queue-based reference model, directed cases and random stalls.
module tb_fd_skid_buffer;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 32;
  localparam logic [INSTR_W-1:0] NOP = '0;

  logic               clk = 1'b0;
  logic               rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [INSTR_W-1:0] instr_in, instr_out;
  logic [PC_W-1:0]    pc_in, pc_out;
  logic [1:0]         occupancy;
`ifdef FD_SKID_BUFFER_STATS_EN
  logic [15:0]        flush_drop_cnt;
`endif

  always #5 clk = ~clk;

  fd_skid_buffer #(.INSTR_W(INSTR_W), .PC_W(PC_W), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .pc_in(pc_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr_out(instr_out), .pc_out(pc_out), .occupancy(occupancy)
`ifdef FD_SKID_BUFFER_STATS_EN
    , .flush_drop_cnt(flush_drop_cnt)
`endif
  );

  typedef struct {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two entries plus the last visible PC and drop count.
  entry_t    mq[$];
  logic [31:0] m_last_pc = '0;
  int        m_cnt = 0;
  bit        m_ok = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_last_pc = '0;
      m_cnt     = 0;
      m_ok      = 1;
    end else if (m_ok) begin
      bit acc, tk;
      acc = in_valid && (mq.size() < 2);
      tk  = out_ready && (mq.size() > 0);
      if (flush) begin
        m_cnt = m_cnt + mq.size() + int'(acc);
        if (m_cnt > 65535) m_cnt = 65535;
        mq.delete();
        m_last_pc = '0;
      end else begin
        entry_t e;
        if (tk) void'(mq.pop_front());
        if (acc) begin
          e.instr = instr_in;
          e.pc    = pc_in;
          mq.push_back(e);
        end
        if (mq.size() > 0) m_last_pc = mq[0].pc;
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      check("occupancy", 64'(occupancy), 64'(mq.size()));
      check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      check("in_ready", 64'(in_ready), 64'((mq.size() < 2) && !rst));
      check("instr_out", 64'(instr_out), 64'(mq.size() > 0 ? mq[0].instr : NOP));
      check("pc_out", 64'(pc_out), 64'(mq.size() > 0 ? mq[0].pc : m_last_pc));
      if (out_valid && occupancy == 2'd0) check("valid_with_occ0", 64'(1), 64'(0));
`ifdef FD_SKID_BUFFER_STATS_EN
      check("flush_drop_cnt", 64'(flush_drop_cnt), 64'(m_cnt));
`endif
    end
  end

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [INSTR_W-1:0] ins, input logic [PC_W-1:0] p,
                       input logic ordy);
    rst = r; flush = f; in_valid = iv; instr_in = ins; pc_in = p; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

`ifdef FD_SKID_BUFFER_STATS_EN
  logic [15:0] cnt_before;
`endif

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr_in = '0; pc_in = '0; out_ready = 1'b0;

    // Reset, then one entry.
    drive(1, 0, 0, 16'h0, 32'h0, 1);
    drive(1, 0, 0, 16'h0, 32'h0, 1);
    check("reset_occ", 64'(occupancy), 64'(0));
    check("reset_instr", 64'(instr_out), 64'(NOP));
    check("reset_pc", 64'(pc_out), 64'(0));
    drive(0, 0, 1, 16'h1234, 32'h100, 1);
    check("first_valid", 64'(out_valid), 64'(1));
    check("first_instr", 64'(instr_out), 64'h1234);
    check("first_pc", 64'(pc_out), 64'h100);
    check("first_occ", 64'(occupancy), 64'(1));
    drive(0, 0, 0, 16'h0, 32'h0, 1);
    check("drain_empty_instr", 64'(instr_out), 64'(NOP));
    check("drain_hold_pc", 64'(pc_out), 64'h100);

    // Backpressure.
    drive(0, 0, 1, 16'hA001, 32'h200, 0);
    drive(0, 0, 1, 16'hA002, 32'h204, 0);
    check("bp_occ", 64'(occupancy), 64'(2));
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_head", 64'(instr_out), 64'hA001);
    drive(0, 0, 1, 16'hBEEF, 32'h208, 0);
    check("bp_hold", 64'(instr_out), 64'hA001);
    drive(0, 0, 0, 16'h0, 32'h0, 1);
    check("bp_second", 64'(instr_out), 64'hA002);
    drive(0, 0, 0, 16'h0, 32'h0, 1);
    check("bp_empty", 64'(out_valid), 64'(0));

    // Streaming.
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 16'(i), 32'(32'h300 + 4 * i), 1);
      check("stream_instr", 64'(instr_out), 64'(i));
      check("stream_occ", 64'(occupancy), 64'(1));
      check("stream_ready", 64'(in_ready), 64'(1));
    end
    drive(0, 0, 0, 16'h0, 32'h0, 1);

    // Flush in TWO with in_valid high.
    drive(0, 0, 1, 16'hC001, 32'h400, 0);
    drive(0, 0, 1, 16'hC002, 32'h404, 0);
`ifdef FD_SKID_BUFFER_STATS_EN
    cnt_before = flush_drop_cnt;
`endif
    drive(0, 1, 1, 16'hC003, 32'h408, 0);
    check("flush_occ", 64'(occupancy), 64'(0));
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_instr", 64'(instr_out), 64'(NOP));
    check("flush_pc", 64'(pc_out), 64'(0));
`ifdef FD_SKID_BUFFER_STATS_EN
    check("flush_cnt_inc", 64'(flush_drop_cnt - cnt_before), 64'(2));
`endif

    // Flush together with rst, rst in ONE, rst in TWO.
    drive(0, 0, 1, 16'hD001, 32'h500, 0);
    drive(1, 1, 1, 16'hD002, 32'h504, 0);
    check("rstflush_occ", 64'(occupancy), 64'(0));
    check("rstflush_pc", 64'(pc_out), 64'(0));
`ifdef FD_SKID_BUFFER_STATS_EN
    check("rstflush_cnt", 64'(flush_drop_cnt), 64'(0));
`endif
    drive(0, 0, 1, 16'hD003, 32'h508, 0);
    drive(1, 0, 0, 16'h0, 32'h0, 1);
    check("rst_one_valid", 64'(out_valid), 64'(0));
    check("rst_one_instr", 64'(instr_out), 64'(NOP));
    drive(0, 0, 1, 16'hD004, 32'h50C, 0);
    drive(0, 0, 1, 16'hD005, 32'h510, 0);
    drive(1, 0, 1, 16'hD006, 32'h514, 1);
    check("rst_two_occ", 64'(occupancy), 64'(0));
    drive(0, 0, 1, 16'hD007, 32'h518, 0);
    check("resume_instr", 64'(instr_out), 64'hD007);

    // Random stalls on both sides, no flush.
    for (int i = 0; i < 10000; i++)
      drive(0, 0, 1'($urandom_range(0, 1)), 16'($urandom), $urandom, 1'($urandom_range(0, 1)));

    // Random with occasional flush and reset.
    for (int i = 0; i < 1500; i++)
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
            1'($urandom_range(0, 1)), 16'($urandom), $urandom, 1'($urandom_range(0, 1)));

    drive(0, 0, 0, 16'h0, 32'h0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
